debouncer_array: RTL

DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

---
 rtl/debouncer_pkg.sv | 16 +
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/debouncer_array.sv | 47 ++++
 3 files changed

// File: rtl/debouncer_pkg.sv
// Shared sizing helpers for the debouncer array: the stable-window length,
// the counter width and the channel limit.
package debouncer_pkg;

    localparam int MaxCh = 32;

    // Number of clock cycles the synchronised input must stay constant.
    function automatic int counter_max(input int clk_freq, input int stable_us);
        return (clk_freq / 32'sd1_000_000) * stable_us;
    endfunction

    function automatic int counter_width(input int cmax);
        return $clog2(cmax + 32'sd1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: two-flop synchroniser, saturating stability counter,
// debounced level and registered edge ticks (fall ticks only with DEBOUNCER_ARRAY_FALL_TICK_EN).
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int CounterMax = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    input  logic en_i,
    output logic db_level_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CntW = counter_width(CounterMax);
    localparam logic [CntW-1:0] CntTop = CntW'(CounterMax - 1);

    logic            s1_r;
    logic            s2_r;
    logic [CntW-1:0] cnt_r;
    logic            stable_s;
    logic            db_level_r;
    logic            rise_r;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= sw_i;
            s2_r <= s1_r;
        end
    end

    assign stable_s = en_i && (cnt_r == CntTop);

    // Stability counter: restarts on any change or while disabled, saturates at the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (!en_i) begin
            cnt_r <= '0;
        end else if (s1_r != s2_r) begin
            cnt_r <= '0;
        end else if (!stable_s) begin
            cnt_r <= cnt_r + CntW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Debounced level and rise tick, updated together so the tick marks the level change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_level_r <= 1'b0;
            rise_r     <= 1'b0;
        end else if (stable_s) begin
            db_level_r <= s2_r;
            rise_r     <= s2_r & ~db_level_r;
        end else begin
            db_level_r <= db_level_r;
            rise_r     <= 1'b0;
        end
    end

`ifdef DEBOUNCER_ARRAY_FALL_TICK_EN
    logic fall_r;

    // Fall tick, mirror of the rise tick for the 1->0 level change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fall_r <= 1'b0;
        end else if (stable_s) begin
            fall_r <= ~s2_r & db_level_r;
        end else begin
            fall_r <= 1'b0;
        end
    end

    assign fall_tick_o = fall_r;
`else
    assign fall_tick_o = 1'b0;
`endif

    assign db_level_o  = db_level_r;
    assign rise_tick_o = rise_r;

endmodule

// File: rtl/debouncer_array.sv
// Array of NumCh independent switch debouncers with a combined tick flag.
// Define DEBOUNCER_ARRAY_FALL_TICK_EN to enable the fall-tick outputs.
module debouncer_array
    import debouncer_pkg::*;
#(
    parameter int NumCh        = 4,
    parameter int ClkFreq      = 100_000_000,
    parameter int StableTimeUs = 10_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumCh-1:0] sw_i,
    input  logic [NumCh-1:0] en_i,
    output logic [NumCh-1:0] db_level_o,
    output logic [NumCh-1:0] rise_tick_o,
    output logic [NumCh-1:0] fall_tick_o,
    output logic             any_tick_o
);

    localparam int CounterMax = counter_max(ClkFreq, StableTimeUs);

    if (CounterMax < 2) begin : g_bad_window
        $error("debouncer_array: CounterMax must be at least 2");
    end

    if ((NumCh < 1) || (NumCh > MaxCh)) begin : g_bad_numch
        $error("debouncer_array: NumCh out of range");
    end

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        debounce_channel #(
            .CounterMax (CounterMax)
        ) u_channel (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .sw_i        (sw_i[i]),
            .en_i        (en_i[i]),
            .db_level_o  (db_level_o[i]),
            .rise_tick_o (rise_tick_o[i]),
            .fall_tick_o (fall_tick_o[i])
        );
    end

    // Tick bits are already registered, so the combined flag adds no latency.
    assign any_tick_o = (|rise_tick_o) | (|fall_tick_o);

endmodule
